// File: rtl/isa_pkg.sv
// isa_pkg
// Shared encodings for the 9-bit core: opcode values, the opcode class
// used by the sequencer and ALU, and the sequencer state encoding.
// No ports (package).
package isa_pkg;

  localparam logic [2:0] OP_LOAD  = 3'b100;
  localparam logic [2:0] OP_STORE = 3'b101;
  localparam logic [2:0] OP_JZ    = 3'b110;
  localparam logic [2:0] OP_JMP   = 3'b111;

  typedef enum logic [2:0] {
    CLS_ALU   = 3'd0,
    CLS_LOAD  = 3'd1,
    CLS_STORE = 3'd2,
    CLS_JZ    = 3'd3,
    CLS_JMP   = 3'd4
  } op_class_t;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_FETCH  = 3'd1;
  localparam logic [2:0] ST_DECODE = 3'd2;
  localparam logic [2:0] ST_EXEC   = 3'd3;
  localparam logic [2:0] ST_MEM    = 3'd4;
  localparam logic [2:0] ST_WB     = 3'd5;
  localparam logic [2:0] ST_HALT   = 3'd6;

  typedef enum logic [2:0] {
    SEQ_IDLE   = ST_IDLE,
    SEQ_FETCH  = ST_FETCH,
    SEQ_DECODE = ST_DECODE,
    SEQ_EXEC   = ST_EXEC,
    SEQ_MEM    = ST_MEM,
    SEQ_WB     = ST_WB,
    SEQ_HALT   = ST_HALT
  } seq_state_t;

endpackage

// File: rtl/op_class_decode.sv
// op_class_decode
// Combinational opcode -> instruction class map.
// Ports:
//   opcode   in  3  mach_code[8:6]
//   op_class out    decoded class (0xx opcodes are all ALU)
module op_class_decode
  import isa_pkg::*;
(
  input  logic [2:0] opcode,
  output op_class_t  op_class
);

  always_comb begin
    case (opcode)
      OP_LOAD:  op_class = CLS_LOAD;
      OP_STORE: op_class = CLS_STORE;
      OP_JZ:    op_class = CLS_JZ;
      OP_JMP:   op_class = CLS_JMP;
      default:  op_class = CLS_ALU;
    endcase
  end

endmodule

// File: rtl/core_sequencer.sv
// core_sequencer
// Multi-cycle instruction sequencer for the 9-bit core. Steps each
// instruction through fetch/decode/exec/mem/wb and issues one-cycle
// enables so memory and register file are never strobed together.
// Ports:
//   clk, reset (sync, active-high), start (pulse, IDLE only)
//   opcode[2:0], pc[9:0], zero_flag       - datapath status
//   ir_load, pc_en, branch_take            - fetch / PC control
//   reg_write_en, wb_sel_mem               - register writeback
//   mem_read_en, mem_write_en              - data memory
//   busy, done, instr_count[CNT_W-1:0]     - status
//
// state  | meaning
// IDLE   | waiting for start
// FETCH  | load IR, or halt when pc == DONE_PC
// DECODE | capture opcode class
// EXEC   | ALU cycle; branches retire here
// MEM    | load read / store write (store retires)
// WB     | register write, retire
// HALT   | terminal until reset
module core_sequencer
  import isa_pkg::*;
#(
  parameter int DONE_PC = 128,
  parameter int CNT_W   = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       opcode,
  input  logic [9:0]       pc,
  input  logic             zero_flag,
  output logic             ir_load,
  output logic             pc_en,
  output logic             branch_take,
  output logic             reg_write_en,
  output logic             wb_sel_mem,
  output logic             mem_read_en,
  output logic             mem_write_en,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [9:0] DONE_PC_V = 10'(DONE_PC);

  logic [2:0] state;
  logic [2:0] state_nxt;
  op_class_t  cls;
  op_class_t  dec_cls;
  logic       at_done_pc;

  op_class_decode u_op_class_decode (
    .opcode   (opcode),
    .op_class (dec_cls)
  );

  assign at_done_pc = (pc == DONE_PC_V);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (start) state_nxt = ST_FETCH;
      ST_FETCH:  state_nxt = at_done_pc ? ST_HALT : ST_DECODE;
      ST_DECODE: state_nxt = (dec_cls == CLS_LOAD || dec_cls == CLS_STORE) ? ST_MEM : ST_EXEC;
      ST_EXEC:   state_nxt = (cls == CLS_ALU) ? ST_WB : ST_FETCH;
      ST_MEM:    state_nxt = (cls == CLS_STORE) ? ST_FETCH : ST_WB;
      ST_WB:     state_nxt = ST_FETCH;
      ST_HALT:   state_nxt = ST_HALT;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      cls         <= CLS_ALU;
      done        <= 1'b0;
      instr_count <= '0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == ST_HALT);
      if (state == ST_DECODE) cls <= dec_cls;
      if (pc_en && instr_count != '1) instr_count <= instr_count + CNT_W'(1);
    end
  end

  // Strobes are masked while reset is asserted so an aborted instruction
  // issues nothing in the reset cycle itself.
  always_comb begin
    ir_load      = 1'b0;
    pc_en        = 1'b0;
    branch_take  = 1'b0;
    reg_write_en = 1'b0;
    wb_sel_mem   = 1'b0;
    mem_read_en  = 1'b0;
    mem_write_en = 1'b0;
    busy         = 1'b0;
    if (!reset) begin
      busy = (state != ST_IDLE) && (state != ST_HALT);
      case (state)
        ST_FETCH: ir_load = !at_done_pc;
        ST_EXEC: begin
          if (cls == CLS_JZ || cls == CLS_JMP) begin
            pc_en       = 1'b1;
            branch_take = (cls == CLS_JMP) || zero_flag;
          end
        end
        ST_MEM: begin
          if (cls == CLS_STORE) begin
            mem_write_en = 1'b1;
            pc_en        = 1'b1;
          end else begin
            mem_read_en = 1'b1;
          end
        end
        ST_WB: begin
          reg_write_en = 1'b1;
          pc_en        = 1'b1;
          wb_sel_mem   = (cls == CLS_LOAD);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// tb_core_sequencer
// Scoreboarded bench for core_sequencer: per-cycle expected strobe
// vectors are queued per instruction and popped as the DUT runs.
module tb_core_sequencer;
  import isa_pkg::*;

  // Narrow counter so the saturation run stays short.
  localparam int CNT_W = 8;
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic clk = 1'b0;
  logic reset, start, zero_flag;
  logic [2:0] opcode;
  logic [9:0] pc;
  logic ir_load, pc_en, branch_take, reg_write_en, wb_sel_mem;
  logic mem_read_en, mem_write_en, busy, done;
  logic [CNT_W-1:0] instr_count;
  logic [8:0] outs;

  logic [8:0] sb[$];
  int compared = 0;
  int mismatched = 0;
  logic [CNT_W-1:0] exp_cnt = '0;

  always #5 clk = ~clk;

  core_sequencer #(.DONE_PC(128), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .opcode       (opcode),
    .pc           (pc),
    .zero_flag    (zero_flag),
    .ir_load      (ir_load),
    .pc_en        (pc_en),
    .branch_take  (branch_take),
    .reg_write_en (reg_write_en),
    .wb_sel_mem   (wb_sel_mem),
    .mem_read_en  (mem_read_en),
    .mem_write_en (mem_write_en),
    .busy         (busy),
    .done         (done),
    .instr_count  (instr_count)
  );

  // {ir_load, pc_en, branch_take, reg_we, wb_sel_mem, mem_rd, mem_wr, busy, done}
  assign outs = {ir_load, pc_en, branch_take, reg_write_en, wb_sel_mem,
                 mem_read_en, mem_write_en, busy, done};

  function automatic int n_phases(input logic [2:0] op);
    return (op == OP_STORE || op == OP_JZ || op == OP_JMP) ? 3 : 4;
  endfunction

  function automatic logic [8:0] model(input logic [2:0] op, input int ph, input logic zf);
    case (ph)
      0: return 9'b100000010;
      1: return 9'b000000010;
      2: begin
        case (op)
          OP_LOAD:  return 9'b000001010;
          OP_STORE: return 9'b010000110;
          OP_JZ:    return {2'b01, zf, 6'b000010};
          OP_JMP:   return 9'b011000010;
          default:  return 9'b000000010;
        endcase
      end
      default: return (op == OP_LOAD) ? 9'b010110010 : 9'b010100010;
    endcase
  endfunction

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1; opcode = 3'b000; pc = 10'd0;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  // Runs one instruction starting in FETCH; opcode and zero_flag are
  // scrambled in the cycles where the DUT must ignore them.
  task automatic run_instr(input string name, input logic [2:0] op,
                           input logic [9:0] pcv, input logic zf);
    int n;
    logic [8:0] exp;
    logic [8:0] obs;
    n = n_phases(op);
    for (int p = 0; p < n; p++) sb.push_back(model(op, p, zf));
    for (int p = 0; p < n; p++) begin
      @(negedge clk);
      opcode    = (p < 2) ? op : 3'($urandom);
      zero_flag = (p == 2) ? zf : 1'($urandom);
      pc        = pcv;
      start     = 1'($urandom);
      #1;
      obs = outs;
      exp = sb.pop_front();
      compared++;
      if (obs !== exp) begin
        mismatched++;
        $display("FAIL %s phase %0d strobes: got %b want %b", name, p, obs, exp);
      end
      compared++;
      if (instr_count !== exp_cnt) begin
        mismatched++;
        $display("FAIL %s phase %0d instr_count: got %0d want %0d", name, p, instr_count, exp_cnt);
      end
      compared++;
      if ((int'(reg_write_en) + int'(mem_read_en) + int'(mem_write_en)) > 1) begin
        mismatched++;
        $display("FAIL %s phase %0d exclusive strobes: got %b%b%b want at most one",
                 name, p, reg_write_en, mem_read_en, mem_write_en);
      end
      if (exp[7] && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 1'b1;
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; start = 1'b0; opcode = 3'b000; pc = 10'd0; zero_flag = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compared++;
    if (outs !== 9'b0 || instr_count !== '0) begin
      mismatched++;
      $display("FAIL reset_hold: got %b cnt %0d want 0 cnt 0", outs, instr_count);
    end
    reset = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk); #1;
      compared++;
      if (outs !== 9'b0 || instr_count !== '0) begin
        mismatched++;
        $display("FAIL idle_no_start cycle %0d: got %b cnt %0d want 0", i, outs, instr_count);
      end
    end
  endtask

  task automatic test_alu();
    pulse_start();
    run_instr("alu000", 3'b000, 10'd0, 1'b0);
    @(posedge clk); #1;
    compared++;
    if (instr_count !== CNT_W'(1)) begin
      mismatched++;
      $display("FAIL alu_count: got %0d want 1", instr_count);
    end
  endtask

  task automatic test_back_to_back();
    run_instr("load", OP_LOAD, 10'd1, 1'b0);
    run_instr("store", OP_STORE, 10'd2, 1'b1);
  endtask

  task automatic test_branches();
    run_instr("jz_taken", OP_JZ, 10'd3, 1'b1);
    run_instr("jz_not", OP_JZ, 10'd4, 1'b0);
    run_instr("jmp", OP_JMP, 10'd5, 1'b0);
    for (int i = 1; i < 4; i++) run_instr("alu_op", 3'(i), 10'(5 + i), 1'b1);
  endtask

  task automatic test_halt();
    @(negedge clk);
    pc = 10'd128; opcode = OP_JMP; start = 1'b0; #1;
    compared++;
    if (outs !== 9'b000000010) begin
      mismatched++;
      $display("FAIL halt_fetch: got %b want 000000010", outs);
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      start = ~i[0]; pc = 10'(i); #1;
      compared++;
      if (outs !== 9'b000000001) begin
        mismatched++;
        $display("FAIL halt_hold cycle %0d: got %b want 000000001", i, outs);
      end
    end
    start = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk); #1;
      compared++;
      if (outs !== 9'b0 || instr_count !== '0) begin
        mismatched++;
        $display("FAIL halt_reset cycle %0d: got %b cnt %0d want 0", i, outs, instr_count);
      end
    end
  endtask

  task automatic test_reset_in_wb();
    logic [8:0] exp;
    pulse_start();
    for (int p = 0; p < 3; p++) sb.push_back(model(3'b000, p, 1'b0));
    for (int p = 0; p < 3; p++) begin
      @(negedge clk);
      opcode = (p < 2) ? 3'b000 : 3'($urandom);
      pc = 10'd20; #1;
      exp = sb.pop_front();
      compared++;
      if (outs !== exp) begin
        mismatched++;
        $display("FAIL rst_wb phase %0d: got %b want %b", p, outs, exp);
      end
    end
    @(negedge clk);
    reset = 1'b1; #1;
    compared++;
    if (pc_en !== 1'b0 || reg_write_en !== 1'b0) begin
      mismatched++;
      $display("FAIL rst_wb_strobe: got pc_en %b reg_we %b want 0 0", pc_en, reg_write_en);
    end
    @(posedge clk);
    #1 reset = 1'b0;
    exp_cnt = '0;
    @(negedge clk); #1;
    compared++;
    if (outs !== 9'b0 || instr_count !== '0) begin
      mismatched++;
      $display("FAIL rst_wb_idle: got %b cnt %0d want 0", outs, instr_count);
    end
  endtask

  task automatic test_saturation();
    pulse_start();
    for (int i = 0; i < (1 << CNT_W) + 4; i++)
      run_instr("sat", 3'(i % 4), 10'(i % 128), 1'b0);
    @(posedge clk); #1;
    compared++;
    if (instr_count !== CNT_MAX) begin
      mismatched++;
      $display("FAIL saturation: got %0d want %0d", instr_count, CNT_MAX);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_alu();
    test_back_to_back();
    test_branches();
    test_halt();
    test_reset_in_wb();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
